// File: rtl/a2d_scan_sched.sv
// Autonomous ADC128S scan scheduler: each period it walks the enabled channels in
// ascending order (prime + real conversion per channel) and fills an 8-entry bank.
module a2d_scan_sched #(
  parameter int PERIOD = 20000,
  parameter int TMO    = 2047,
  parameter bit INVERT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  ch_mask,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  input  logic [2:0]  rd_chnl,
  output logic [11:0] rd_data,
  output logic [7:0]  ch_vld,
  output logic        rnd_done,
  output logic        busy,
  output logic        tmo_err,
  output logic        overrun
);

  localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, WAIT_TMR, PRIME_STRT, PRIME_WAIT, CNV_STRT, CNV_WAIT, STORE
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      per_q, per_d;
  logic [TW-1:0]      wdog_q, wdog_d;
  logic [2:0]         cur_q, cur_d;
  logic [7:0]         mask_q, mask_d;
  logic [2:0]         chnnl_q, chnnl_d;
  logic               strt_q, strt_d;
  logic               rnd_q, rnd_d;
  logic               tmo_q, tmo_d;
  logic               ovr_q, ovr_d;
  logic [7:0]         vld_q, vld_d;
  logic               cmplt_q;
  logic signed [11:0] bank_q [8];

  logic               tick;
  logic               busy_w;
  logic               cmplt_rise;
  logic               advance;
  logic               wr_en;
  logic [3:0]         first_ch;
  logic [3:0]         nxt_ch;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [3:0] next_set(input logic [7:0] m, input logic [3:0] from);
    logic [3:0] r;
    r = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // The ADC128S analog front end is inverting, so the raw code is optionally flipped.
  function automatic logic signed [11:0] store_val(input logic [11:0] r);
    return INVERT ? $signed(~r) : $signed(r);
  endfunction

  assign tick       = (per_q == PW'(PERIOD - 1));
  assign busy_w     = !((state_q == IDLE) || (state_q == WAIT_TMR));
  assign cmplt_rise = cnv_cmplt & ~cmplt_q;
  assign first_ch   = next_set(ch_mask, 4'd0);
  assign nxt_ch     = next_set(mask_q, {1'b0, cur_q} + 4'd1);

  always_comb begin
    state_d = state_q;
    per_d   = (!en || tick) ? '0 : per_q + PW'(1);
    wdog_d  = wdog_q;
    cur_d   = cur_q;
    mask_d  = mask_q;
    chnnl_d = chnnl_q;
    strt_d  = 1'b0;
    rnd_d   = 1'b0;
    tmo_d   = tmo_q;
    ovr_d   = ovr_q | (tick & busy_w);
    vld_d   = vld_q;
    advance = 1'b0;
    wr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) state_d = WAIT_TMR;
      end
      WAIT_TMR: begin
        if (!en) begin
          state_d = IDLE;
        end else if (tick) begin
          if (first_ch[3]) begin
            cur_d   = first_ch[2:0];
            mask_d  = ch_mask;
            state_d = PRIME_STRT;
          end else begin
            rnd_d = 1'b1;
          end
        end
      end
      PRIME_STRT, CNV_STRT: begin
        strt_d  = 1'b1;
        chnnl_d = cur_q;
        wdog_d  = '0;
        state_d = (state_q == PRIME_STRT) ? PRIME_WAIT : CNV_WAIT;
      end
      PRIME_WAIT, CNV_WAIT: begin
        if (cmplt_rise) begin
          state_d = (state_q == PRIME_WAIT) ? CNV_STRT : STORE;
        end else if (wdog_q == TW'(TMO)) begin
          tmo_d   = 1'b1;
          advance = 1'b1;
        end else begin
          wdog_d = wdog_q + TW'(1);
        end
      end
      STORE: begin
        wr_en        = 1'b1;
        vld_d[cur_q] = 1'b1;
        advance      = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A timeout skips the channel exactly like a completed store, minus the write.
    if (advance) begin
      if (nxt_ch[3]) begin
        cur_d   = nxt_ch[2:0];
        state_d = PRIME_STRT;
      end else begin
        rnd_d   = 1'b1;
        state_d = en ? WAIT_TMR : IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      per_q   <= '0;
      wdog_q  <= '0;
      cur_q   <= '0;
      mask_q  <= '0;
      chnnl_q <= '0;
      strt_q  <= 1'b0;
      rnd_q   <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
      vld_q   <= '0;
      cmplt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      wdog_q  <= wdog_d;
      cur_q   <= cur_d;
      mask_q  <= mask_d;
      chnnl_q <= chnnl_d;
      strt_q  <= strt_d;
      rnd_q   <= rnd_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
      vld_q   <= vld_d;
      cmplt_q <= cnv_cmplt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) bank_q[i] <= '0;
    end else if (wr_en) begin
      bank_q[cur_q] <= store_val(res);
    end
  end

  assign strt_cnv = strt_q;
  assign chnnl    = chnnl_q;
  assign rd_data  = bank_q[rd_chnl];
  assign ch_vld   = vld_q;
  assign rnd_done = rnd_q;
  assign busy     = busy_w;
  assign tmo_err  = tmo_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_a2d_scan_sched.sv
// Bench for a2d_scan_sched: three instances (normal scan, stuck converter, short period)
// each driven by a small behavioural ADC128S/A2D_intf model.
module tb_a2d_scan_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  // main instance
  logic        m_en = 1'b0;
  logic [7:0]  m_mask = '0;
  logic        m_strt;
  logic [2:0]  m_chnnl;
  logic        m_cmplt = 1'b0;
  logic [11:0] m_res = '0;
  logic [2:0]  m_rd = '0;
  logic [11:0] m_rdata;
  logic [7:0]  m_vld;
  logic        m_rnd, m_busy, m_tmo, m_ovr;

  // stuck-converter instance
  logic        t_en = 1'b0;
  logic [7:0]  t_mask = '0;
  logic        t_strt;
  logic [2:0]  t_chnnl;
  logic        t_cmplt = 1'b0;
  logic [11:0] t_res = '0;
  logic [2:0]  t_rd = '0;
  logic [11:0] t_rdata;
  logic [7:0]  t_vld;
  logic        t_rnd, t_busy, t_tmo, t_ovr;

  // short-period instance
  logic        o_en = 1'b0;
  logic [7:0]  o_mask = '0;
  logic        o_strt;
  logic [2:0]  o_chnnl;
  logic        o_cmplt = 1'b0;
  logic [11:0] o_res = '0;
  logic [2:0]  o_rd = '0;
  logic [11:0] o_rdata;
  logic [7:0]  o_vld;
  logic        o_rnd, o_busy, o_tmo, o_ovr;

  a2d_scan_sched #(.PERIOD(2000), .TMO(2047), .INVERT(1'b1)) u_main (
    .clk(clk), .rst_n(rst_n), .en(m_en), .ch_mask(m_mask), .strt_cnv(m_strt),
    .chnnl(m_chnnl), .cnv_cmplt(m_cmplt), .res(m_res), .rd_chnl(m_rd), .rd_data(m_rdata),
    .ch_vld(m_vld), .rnd_done(m_rnd), .busy(m_busy), .tmo_err(m_tmo), .overrun(m_ovr));

  a2d_scan_sched #(.PERIOD(400), .TMO(50), .INVERT(1'b1)) u_tmo (
    .clk(clk), .rst_n(rst_n), .en(t_en), .ch_mask(t_mask), .strt_cnv(t_strt),
    .chnnl(t_chnnl), .cnv_cmplt(t_cmplt), .res(t_res), .rd_chnl(t_rd), .rd_data(t_rdata),
    .ch_vld(t_vld), .rnd_done(t_rnd), .busy(t_busy), .tmo_err(t_tmo), .overrun(t_ovr));

  a2d_scan_sched #(.PERIOD(100), .TMO(2047), .INVERT(1'b0)) u_ovr (
    .clk(clk), .rst_n(rst_n), .en(o_en), .ch_mask(o_mask), .strt_cnv(o_strt),
    .chnnl(o_chnnl), .cnv_cmplt(o_cmplt), .res(o_res), .rd_chnl(o_rd), .rd_data(o_rdata),
    .ch_vld(o_vld), .rnd_done(o_rnd), .busy(o_busy), .tmo_err(o_tmo), .overrun(o_ovr));

  // Converter model: returns the channel addressed by the previous conversion,
  // six cycles after the start pulse. The main path is analog-inverted.
  logic [11:0] m_vals [8];
  int          m_lat = 0;
  logic [2:0]  m_prev = '0, m_src = '0;
  always @(negedge clk) begin
    if (m_strt) begin
      m_cmplt = 1'b0;
      m_src   = m_prev;
      m_prev  = m_chnnl;
      m_lat   = 6;
    end else if (m_lat > 0) begin
      m_lat = m_lat - 1;
      if (m_lat == 0) begin
        m_res   = ~m_vals[m_src];
        m_cmplt = 1'b1;
      end
    end
  end

  logic [11:0] o_vals [8];
  int          o_lat = 0;
  logic [2:0]  o_prev = '0, o_src = '0;
  always @(negedge clk) begin
    if (o_strt) begin
      o_cmplt = 1'b0;
      o_src   = o_prev;
      o_prev  = o_chnnl;
      o_lat   = 6;
    end else if (o_lat > 0) begin
      o_lat = o_lat - 1;
      if (o_lat == 0) begin
        o_res   = o_vals[o_src];
        o_cmplt = 1'b1;
      end
    end
  end

  int         m_strt_cnt = 0, m_rnd_cnt = 0, o_rnd_cnt = 0;
  logic [2:0] m_seq [$];
  logic [2:0] o_seq [$];
  always @(negedge clk) begin
    if (m_strt) begin m_strt_cnt++; m_seq.push_back(m_chnnl); end
    if (m_rnd) m_rnd_cnt++;
    if (o_strt) o_seq.push_back(o_chnnl);
    if (o_rnd) o_rnd_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  typedef struct {
    logic [7:0]        mask;
    logic [7:0][11:0]  vals;
    logic              drop_early;
    int                exp_pulses;
    logic [7:0]        exp_vld;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [7:0][11:0] dflt;
    int sb, qb, rb, j, d;
    logic seen;

    for (int i = 0; i < 8; i++) dflt[i] = 12'(12'h111 * (i + 1));
    vecs[0].mask = 8'h08; vecs[0].vals = dflt; vecs[0].vals[3] = 12'hA5C;
    vecs[0].drop_early = 1'b0; vecs[0].exp_pulses = 2;  vecs[0].exp_vld = 8'h08;
    vecs[1].mask = 8'hFF; vecs[1].vals = dflt;
    vecs[1].drop_early = 1'b0; vecs[1].exp_pulses = 16; vecs[1].exp_vld = 8'hFF;
    vecs[2].mask = 8'h82; vecs[2].vals = dflt;
    vecs[2].drop_early = 1'b1; vecs[2].exp_pulses = 4;  vecs[2].exp_vld = 8'h82;
    vecs[3].mask = 8'h00; vecs[3].vals = dflt;
    vecs[3].drop_early = 1'b0; vecs[3].exp_pulses = 0;  vecs[3].exp_vld = 8'h00;
    for (int i = 0; i < 8; i++) begin m_vals[i] = dflt[i]; o_vals[i] = dflt[i]; end

    // reset state of all instances
    cyc(2);
    chk("rst_strt", {m_strt, t_strt, o_strt}, 0);
    chk("rst_chnnl", {m_chnnl, t_chnnl, o_chnnl}, 0);
    chk("rst_vld", {m_vld, t_vld, o_vld}, 0);
    chk("rst_flags", {m_rnd, m_busy, m_tmo, m_ovr, t_rnd, t_busy, t_tmo, t_ovr,
                      o_rnd, o_busy, o_tmo, o_ovr}, 0);
    chk("rst_rdata", {m_rdata, t_rdata, o_rdata}, 0);

    // table-driven scan rounds on the main instance
    for (int k = 0; k < 4; k++) begin
      do_reset();
      for (int i = 0; i < 8; i++) m_vals[i] = vecs[k].vals[i];
      m_mask = vecs[k].mask;
      sb = m_strt_cnt; qb = m_seq.size(); rb = m_rnd_cnt;
      m_en = 1'b1;
      for (int c = 0; c < 4500; c++) begin
        cyc(1);
        if (vecs[k].drop_early && m_en && (m_strt_cnt > sb)) m_en = 1'b0;
        if (m_rnd_cnt > rb) break;
      end
      m_en = 1'b0;
      cyc(4);
      chk($sformatf("v%0d_rnd_cnt", k), m_rnd_cnt - rb, 1);
      chk($sformatf("v%0d_pulses", k), m_strt_cnt - sb, vecs[k].exp_pulses);
      j = qb;
      for (int ch = 0; ch < 8; ch++) begin
        if (vecs[k].mask[ch]) begin
          for (int r = 0; r < 2; r++) begin
            chk($sformatf("v%0d_seq%0d", k, j - qb),
                (j < m_seq.size()) ? 32'(m_seq[j]) : 32'hFFFF_FFFF, ch);
            j++;
          end
        end
      end
      chk($sformatf("v%0d_vld", k), m_vld, vecs[k].exp_vld);
      for (int ch = 0; ch < 8; ch++) begin
        m_rd = 3'(ch);
        #1;
        chk($sformatf("v%0d_bank%0d", k, ch), m_rdata,
            vecs[k].mask[ch] ? vecs[k].vals[ch] : 12'h000);
      end
      chk($sformatf("v%0d_idle", k), {m_busy, m_tmo, m_ovr}, 0);
    end

    // asynchronous reset while the real conversion on ch2 is in flight
    do_reset();
    for (int i = 0; i < 8; i++) m_vals[i] = dflt[i];
    m_mask = 8'h04; m_rd = 3'd2;
    sb = m_strt_cnt;
    m_en = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      cyc(1);
      if (m_strt_cnt - sb == 2) begin seen = 1'b1; break; end
    end
    chk("arst_reached_cnv_wait", seen, 1);
    chk("arst_pre_busy", m_busy, 1);
    chk("arst_pre_chnnl", m_chnnl, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", m_busy, 0);
    chk("arst_chnnl", m_chnnl, 0);
    chk("arst_others", {m_strt, m_rnd, m_tmo, m_ovr, m_vld, m_rdata}, 0);
    cyc(2);
    rst_n = 1'b1;
    sb = m_strt_cnt; qb = m_seq.size(); rb = m_rnd_cnt;
    for (int c = 0; c < 2500; c++) begin
      cyc(1);
      if (m_rnd_cnt > rb) break;
    end
    m_en = 1'b0;
    cyc(4);
    chk("arst_restart_pulses", m_strt_cnt - sb, 2);
    chk("arst_restart_seq", (m_seq.size() >= qb + 2) ? {m_seq[qb], m_seq[qb+1]} : 6'h3F, 6'o22);
    chk("arst_restart_bank2", m_rdata, 12'h333);
    chk("arst_restart_vld", m_vld, 8'h04);

    // stuck converter: watchdog abort
    t_mask = 8'h01;
    t_en = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      cyc(1);
      if (t_strt) begin seen = 1'b1; break; end
    end
    chk("tmo_first_strt", seen, 1);
    chk("tmo_strt_chnnl", t_chnnl, 0);
    d = 0;
    for (int c = 0; c < 200; c++) begin
      cyc(1);
      d++;
      if (t_tmo) break;
    end
    chk("tmo_err_set", t_tmo, 1);
    chk("tmo_latency_in_45_56", (d >= 45) && (d <= 56), 1);
    chk("tmo_rnd_done", t_rnd, 1);
    cyc(1);
    chk("tmo_back_to_wait", t_busy, 0);
    chk("tmo_no_store", {t_vld, t_rdata}, 0);
    t_en = 1'b0;
    cyc(3);
    chk("tmo_sticky", t_tmo, 1);
    chk("tmo_no_overrun", t_ovr, 0);

    // short period: rounds overrun but still complete in order
    o_mask = 8'hFF;
    rb = o_rnd_cnt; qb = o_seq.size();
    o_en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      cyc(1);
      if (o_rnd_cnt - rb >= 2) break;
    end
    o_en = 1'b0;
    cyc(4);
    chk("ovr_two_rounds", o_rnd_cnt - rb, 2);
    chk("ovr_overrun", o_ovr, 1);
    chk("ovr_no_tmo", o_tmo, 0);
    chk("ovr_vld", o_vld, 8'hFF);
    j = qb;
    for (int r = 0; r < 32; r++) begin
      chk($sformatf("ovr_seq%0d", r), (j < o_seq.size()) ? 32'(o_seq[j]) : 32'hFFFF_FFFF,
          (r % 16) / 2);
      j++;
    end
    for (int ch = 0; ch < 8; ch++) begin
      o_rd = 3'(ch);
      #1;
      chk($sformatf("ovr_bank%0d", ch), o_rdata, dflt[ch]);
    end
    chk("ovr_idle", o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/a2d_scan_sched.md
Name: a2d_scan_sched

Overview:
- Autonomous scan scheduler sitting in front of A2D_intf.
- Periodically walks the enabled ADC128S channels in ascending order.
- Per channel: one priming conversion (discarded, since the ADC returns the previously addressed channel), then one real conversion.
- Stores the real result, with optional inversion, in an 8-entry result bank read by the rest of the design.

Parameters:
- PERIOD, 20000: clock cycles between scan-round starts (≥ 2).
- TMO, 2047: max cycles to wait for conversion complete before abort.
- INVERT, 1: 1 → store ~res (ADC128S analog path is inverted), 0 → store res.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable
- ch_mask  in  8  per-channel scan enable, bit i = channel i
- strt_cnv  out  1  one-cycle start pulse to A2D_intf
- chnnl  out  3  channel select to A2D_intf, held stable from strt_cnv until completion
- cnv_cmplt  in  1  A2D_intf completion (level, rises once per conversion)
- res  in  12  A2D_intf result
- rd_chnl  in  3  result bank read address
- rd_data  out  12  combinational read of bank[rd_chnl]
- ch_vld  out  8  bit i set once bank[i] has been written
- rnd_done  out  1  one-cycle pulse when a round completes
- busy  out  1  high in any state other than IDLE/WAIT_TMR
- tmo_err  out  1  sticky: a conversion timed out
- overrun  out  1  sticky: period expired while busy

Behaviour:
- Reset values:
  - All outputs 0.
  - chnnl = 0; bank entries = 0; ch_vld = 0.
  - Period counter = 0; state = IDLE.
  - Reset mid-conversion returns to IDLE immediately. The next start re-primes.
- Completion detect: cmplt_rise = cnv_cmplt & ~cnv_cmplt_q, registered edge detect. It is honoured only in PRIME_WAIT/CNV_WAIT and ignored elsewhere.
- Period counter:
  - Free-runs 0..PERIOD-1 while en = 1. Held at 0 while en = 0.
  - tick = 1 when the counter equals PERIOD-1.
- State machine:
  - IDLE:
    - en = 1 → WAIT_TMR.
  - WAIT_TMR:
    - en = 0 → IDLE.
    - On tick with ch_mask ≠ 0: load cur = lowest set bit of ch_mask → PRIME_STRT.
    - On tick with ch_mask = 0: pulse rnd_done, stay.
  - PRIME_STRT:
    - Drive chnnl = cur and strt_cnv = 1 for exactly one cycle.
    - Clear the watchdog → PRIME_WAIT.
  - PRIME_WAIT:
    - On cmplt_rise → CNV_STRT. Result discarded.
  - CNV_STRT:
    - Same as PRIME_STRT with the same chnnl → CNV_WAIT.
  - CNV_WAIT:
    - On cmplt_rise → STORE.
  - STORE:
    - bank[cur] ← INVERT ? ~res : res; set ch_vld[cur].
    - Advance cur to the next set bit above cur in the ch_mask sampled at round start.
    - If one exists → PRIME_STRT.
    - Else: pulse rnd_done → WAIT_TMR, or → IDLE if en = 0.
- Latency: strt_cnv is asserted the cycle after entering *_STRT. bank/ch_vld update at the clock edge leaving STORE. rd_data reflects it the next cycle.
- ch_mask is sampled once at round start. Mid-round changes take effect next round.
- en deasserted mid-round: the current round finishes, then → IDLE. A2D_intf is never left mid-transaction.
- Watchdog:
  - Counts in *_WAIT states.
  - On reaching TMO: set tmo_err; do not write the bank; skip to the next channel as if STORE had been reached.
  - tmo_err is cleared only by reset.
- Overrun:
  - tick while busy sets overrun (sticky).
  - The period counter keeps running; a tick that occurs while busy is not queued.
- chnnl holds the last value in idle states.

Test Plan:
- Model ch3 = 0xA5C, ch_mask = 0x08, en = 1, INVERT = 1, PERIOD = 2000 → exactly 2 strt_cnv pulses with chnnl = 3; then rd_chnl = 3 gives rd_data = 0xA5C; ch_vld = 0x08; one rnd_done.
- Model values 0x111·(i+1) for i = 0..7, ch_mask = 0xFF → chnnl sequence 0,0,1,1,…,7,7 (16 strt_cnv pulses); bank[i] matches the model; ch_vld = 0xFF.
- ch_mask = 0x82 → only channels 1 then 7 are converted; bank[0] stays 0; ch_vld = 0x82.
- Tie cnv_cmplt low, TMO = 50 → tmo_err = 1 about 50 cycles after the first strt_cnv; ch_vld stays 0; the FSM returns to WAIT_TMR.
- PERIOD = 100, ch_mask = 0xFF (a round takes more than 100 cycles) → overrun = 1; rounds still complete in order.
- Assert rst_n low while in CNV_WAIT on ch2 → all outputs 0 asynchronously; after release, the scan restarts with a priming conversion.
